// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter; sequencing comes from the FSM.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  first_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bit_o,
  output logic                  last_bit_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // bit_o is the bit the FSM registers onto the line at the next edge.
  assign bit_o      = sr_q[0];
  assign last_bit_o = (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (first_i) begin
      sr_d  = sr_q >> 1;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = sr_q >> 1;
      if (!last_bit_o) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop; one bit per TX_CLK.
// Define UART_TX_TWO_STOP_EN to add the STP2 input selecting a second stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TX_CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  STP2,
`endif
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_tx_state_e state_q, state_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic paren_q, paren_d;
  logic par_q, par_d;
  logic ld, first, shift;
  logic ser_bit, ser_last;
  logic extra_stop;

`ifdef UART_TX_TWO_STOP_EN
  logic stp2_q, stp2_d;
  logic stop2_q, stop2_d;
  assign extra_stop = stp2_q & ~stop2_q;
`else
  assign extra_stop = 1'b0;
`endif

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk_i     (TX_CLK),
    .rst_i     (rst),
    .load_i    (ld),
    .first_i   (first),
    .shift_i   (shift),
    .data_i    (P_DATA),
    .bit_o     (ser_bit),
    .last_bit_o(ser_last)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    paren_d = paren_q;
    par_d   = par_q;
    ld      = 1'b0;
    first   = 1'b0;
    shift   = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stp2_d  = stp2_q;
    stop2_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          ld      = 1'b1;
          paren_d = PAR_EN;
          par_d   = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
`ifdef UART_TX_TWO_STOP_EN
          stp2_d  = STP2;
`endif
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser_bit;
        first   = 1'b1;
      end
      DATA: begin
        shift = 1'b1;
        if (!ser_last) begin
          tx_d = ser_bit;
        end else if (paren_q) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        tx_d = STOP_BIT;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d = extra_stop;
`endif
        // A second stop bit simply holds the state for one more cycle.
        if (!extra_stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      paren_q <= 1'b0;
      par_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stp2_q  <= 1'b0;
      stop2_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      paren_q <= paren_d;
      par_q   <= par_d;
`ifdef UART_TX_TWO_STOP_EN
      stp2_q  <= stp2_d;
      stop2_q <= stop2_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: frame-level queue model plus literal frame patterns.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pd  = 8'h00;
  logic       dv  = 1'b0;
  logic       pe  = 1'b0;
  logic       pt  = 1'b0;
  logic       s2  = 1'b0;
  logic       tx_out, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .TX_CLK    (clk),
    .rst       (rst),
    .P_DATA    (pd),
    .DATA_VALID(dv),
    .PAR_EN    (pe),
    .PAR_TYP   (pt),
`ifdef UART_TX_TWO_STOP_EN
    .STP2      (s2),
`endif
    .TX_OUT    (tx_out),
    .busy      (busy)
  );

  // Model: on acceptance the whole frame is expanded into a queue of line bits.
  bit q[$];
  bit m_tx   = 1'b1;
  bit m_busy = 1'b0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      chk_en = 1'b1;
    end else if (!m_busy && dv) begin
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(pd[i]);
      if (pe) q.push_back(pt ? ~(^pd) : (^pd));
      q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
      if (s2) q.push_back(1'b1);
`endif
      m_tx   = q.pop_front();
      m_busy = 1'b1;
    end else if (q.size() > 0) begin
      m_tx   = q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (tx_out !== m_tx || busy !== m_busy) begin
        errors++;
        $display("FAIL model t=%0t: TX_OUT=%b busy=%b, required TX_OUT=%b busy=%b",
                 $time, tx_out, busy, m_tx, m_busy);
      end
    end
  end

  task automatic lit(input string name, input logic etx, input logic ebusy);
    checks++;
    if (tx_out !== etx || busy !== ebusy) begin
      errors++;
      $display("FAIL %s t=%0t: TX_OUT=%b busy=%b, required TX_OUT=%b busy=%b",
               name, $time, tx_out, busy, etx, ebusy);
    end
  endtask

  // exp holds the line sequence with the first transmitted bit at index len-1.
  task automatic run_frame(input string name, input logic [7:0] d, input logic e,
                           input logic t, input logic two, input logic [15:0] exp,
                           input int len);
    @(negedge clk);
    pd = d; pe = e; pt = t; s2 = two; dv = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) dv = 1'b0;
      lit(name, exp[len-1-i], 1'b1);
    end
    @(negedge clk);
    lit({name, "_end"}, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] f1, f2;
    // Reset held with a pending request: nothing may be accepted.
    dv = 1'b1; pd = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("reset", 1'b1, 1'b0);
    end
    rst = 1'b0; dv = 1'b0;
    @(negedge clk);
    lit("post_reset", 1'b1, 1'b0);

    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 16'b01010010101, 11);
    run_frame("01_odd",  8'h01, 1'b1, 1'b1, 1'b0, 16'b01000000001, 11);
    run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 1'b0, 16'b0111111111, 10);

    // Back-to-back with data changed mid-frame.
    f1 = 16'b0001111001;
    f2 = 16'b0110000111;
    @(negedge clk);
    pd = 8'h3C; pe = 1'b0; pt = 1'b0; s2 = 1'b0; dv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) pd = 8'hC3;
      lit("b2b_first", f1[9-i], 1'b1);
    end
    @(negedge clk);
    lit("b2b_gap", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) dv = 1'b0;
      lit("b2b_second", f2[9-i], 1'b1);
    end
    @(negedge clk);
    lit("b2b_end", 1'b1, 1'b0);

    // Reset during data bit 4 of 0x55.
    @(negedge clk);
    pd = 8'h55; pe = 1'b0; dv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) dv = 1'b0;
    end
    lit("bit4", 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    lit("abort", 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    lit("abort_idle", 1'b1, 1'b0);
    run_frame("after_abort", 8'h96, 1'b1, 1'b0, 1'b0, 16'b00110100101, 11);

`ifdef UART_TX_TWO_STOP_EN
    run_frame("two_stop", 8'h00, 1'b0, 1'b0, 1'b1, 16'b00000000011, 11);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: the TX-direction counterpart of the system's UART receiver.
- Accepts a parallel byte plus parity configuration and serialises one frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
- Emits one bit per TX_CLK cycle; TX_CLK is already divided down to the bit rate upstream.
- Line idles high; frame format matches what the receiver checks (PAR_EN/PAR_TYP semantics, stop = 1).

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>=5).

Ports:
- TX_CLK  in  1  bit-rate clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  parallel data to send.
- DATA_VALID  in  1  request; P_DATA/PAR_EN/PAR_TYP are valid while high.
- PAR_EN  in  1  1 = insert parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd parity.
- TX_OUT  out  1  serial line, registered.
- busy  out  1  high while a frame is in flight, registered.

Behaviour:
- Clock and reset: one clock (TX_CLK); reset is synchronous and active-high on rst.
- Reset values: TX_OUT=1, busy=0, state=IDLE, shift register and counters 0.
- Reset mid-frame aborts at the next edge:
  - TX_OUT returns to 1 and busy to 0 at that edge; no partial-frame recovery.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance rule:
  - A request is accepted on a posedge with DATA_VALID=1 and state=IDLE.
  - P_DATA, PAR_EN and PAR_TYP are latched.
  - Parity is computed from the latched data: even = ^data, odd = ~^data.
  - At that same edge: state->START, TX_OUT<=0, busy<=1. The start bit therefore appears with zero cycles of latency after the accepting edge.
- START: lasts 1 cycle, then ->DATA with TX_OUT<=data[0].
- DATA:
  - Lasts DATA_WIDTH cycles; bit counter 0..DATA_WIDTH-1; TX_OUT = data[cnt].
  - At cnt=DATA_WIDTH-1, go ->PARITY if the latched PAR_EN=1, else ->STOP.
- PARITY: lasts 1 cycle, TX_OUT=parity bit, then ->STOP.
- STOP:
  - Lasts 1 cycle, TX_OUT=1.
  - At the edge ending STOP: state->IDLE, busy<=0, TX_OUT stays 1.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- DATA_VALID while busy=1 (including the STOP cycle) is ignored. The request is neither queued nor acknowledged; the source must hold DATA_VALID until it sees busy rise.
- Back-to-back: with DATA_VALID held high, the next frame is accepted on the edge after the one returning to IDLE. This gives exactly 1 idle (high) cycle between frames.
- Changes to P_DATA/PAR_EN/PAR_TYP mid-frame have no effect on the current frame.
- Bit counter width is $clog2(DATA_WIDTH); it never wraps inside a frame and is cleared on START.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - Adds input port STP2 (1 bit), latched at acceptance.
  - When the latched STP2=1, STOP lasts 2 cycles (TX_OUT=1 for both); busy stays high through both.
- Undefined:
  - No STP2 port; always exactly one stop bit.

Decomposition:
- Shared package uart_pkg:
  - state enum uart_tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - parity constants PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - line levels LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module uart_tx_serializer:
  - contains the shift register and bit counter;
  - load/shift enables driven by the FSM;
  - outputs the current data bit and a last_bit flag.
- FSM, parity calculation and output mux stay in uart_tx_frame.

Test Plan:
- Reset: rst=1 for 3 cycles -> TX_OUT=1, busy=0 every cycle; DATA_VALID=1 during reset is not accepted.
- 0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; busy high for exactly 11 cycles.
- 0x01, PAR_EN=1, PAR_TYP=1 -> 0,1,0,0,0,0,0,0,0,0,1 (odd parity bit 0); 0xFF with PAR_EN=0 -> 0,1,1,1,1,1,1,1,1,1 (10 cycles).
- DATA_VALID held high with P_DATA changing 0x3C->0xC3 mid-frame -> first frame carries 0x3C; one idle cycle follows; second frame carries 0xC3.
- rst asserted at data bit 4 of 0x55 -> next edge TX_OUT=1, busy=0; a new request two cycles later yields a full, clean frame.
- With UART_TX_TWO_STOP_EN defined: 0x00, PAR_EN=0, STP2=1 -> 0,0,0,0,0,0,0,0,0,1,1; busy high for 11 cycles.
